multimode_timer_core: RTL and testbench

- Parametrised successor to the stopwatch counter datapath: an mm:ss BCD time core with count-up (stopwatch) and count-down (timer with alarm) modes, field adjust, pause/resume and a lap-capture FIFO.
- Sits between the debouncers/joystick decode and the seven-segment/display path.
- The digit outputs drive the existing digit-to-segment converters unchanged.
- Internal prescalers replace the external 1 Hz/2 Hz clock inputs; all logic runs on the one system clock.

---
 rtl/multimode_timer_core.sv | 298 +++++++++++++++++++++++++++++
 tb/tb_multimode_timer_core.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multimode_timer_core.sv
// mm:ss BCD stopwatch / countdown timer with field adjust, pause/resume and a lap-capture FIFO.
// Digits and lap outputs are registered (update one cycle after the causing event); full-FIFO laps are dropped and flagged sticky.

// Generic FIFO with a registered head: head_dat/head_vld reflect the post-push/pop state one cycle later.
module fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic                   core_clk,
  input  logic                   arst_n,
  input  logic                   flush,
  input  logic                   push_vld,
  input  logic [W-1:0]           push_dat,
  output logic                   push_rdy,
  input  logic                   pop_rdy,
  output logic                   head_vld,
  output logic [W-1:0]           head_dat,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] remain;
  logic [W-1:0]  head_dat_q, head_dat_d;
  logic          head_vld_q, head_vld_d;
  logic          do_push, do_pop;

  // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
  assign push_rdy = (count_q != FULL) || pop_rdy;

  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    head_dat_d = head_dat_q;
    do_pop     = pop_rdy && (count_q != '0);
    do_push    = push_vld && ((count_q != FULL) || do_pop);
    remain     = count_q - CW'(do_pop);
    if (do_push) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    count_d = remain + CW'(do_push);
    // New head comes from the push itself when nothing older survives the pop.
    if (count_d != '0) begin
      head_dat_d = (remain == '0) ? push_dat : mem_q[rd_ptr_d];
    end
    head_vld_d = (count_d != '0);
    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      head_vld_d = 1'b0;
    end
  end

  always_ff @(posedge core_clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      head_dat_q <= '0;
      head_vld_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      head_dat_q <= head_dat_d;
      head_vld_q <= head_vld_d;
    end
  end

  assign head_dat = head_dat_q;
  assign head_vld = head_vld_q;
  assign count    = count_q;
endmodule

module multimode_timer_core #(
  parameter int TICK_DIV  = 100000000,
  parameter int ADJ_DIV   = 50000000,
  parameter int MAX_MIN   = 59,
  parameter int LAP_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start_stop,
  input  logic                       clear,
  input  logic                       mode,
  input  logic                       adj,
  input  logic                       sel,
  input  logic                       lap,
  input  logic                       lap_rd,
  output logic [3:0]                 minutes_top,
  output logic [3:0]                 minutes_bot,
  output logic [3:0]                 seconds_top,
  output logic [3:0]                 seconds_bot,
  output logic                       running,
  output logic                       alarm,
  output logic [15:0]                lap_data,
  output logic                       lap_valid,
  output logic [$clog2(LAP_DEPTH):0] lap_count,
  output logic                       lap_overflow
);
  localparam int TW  = $clog2(TICK_DIV);
  localparam int ADW = $clog2(ADJ_DIV);
  localparam logic [TW-1:0]  TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [ADW-1:0] ADJ_LAST  = ADW'(ADJ_DIV - 1);
  localparam logic [3:0]     MAX_MT    = 4'(MAX_MIN / 10);
  localparam logic [3:0]     MAX_MB    = 4'(MAX_MIN % 10);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_PAUSE,
    S_ADJUST,
    S_ALARM
  } state_t;

  state_t         state_q, state_d;
  logic [15:0]    cnt_q, cnt_d;
  logic           mode_q, mode_d;
  logic [TW-1:0]  tick_q, tick_d;
  logic [ADW-1:0] adjc_q, adjc_d;
  logic           ovf_q, ovf_d;
  logic           lap_push, lap_pop, fifo_push_rdy;

  function automatic logic [7:0] min_inc(input logic [7:0] m);
    logic [7:0] r;
    if (m == {MAX_MT, MAX_MB})  r = 8'h00;
    else if (m[3:0] == 4'd9)    r = {m[7:4] + 4'd1, 4'd0};
    else                        r = {m[7:4], m[3:0] + 4'd1};
    return r;
  endfunction

  function automatic logic [7:0] min_dec(input logic [7:0] m);
    logic [7:0] r;
    if (m == 8'h00)             r = {MAX_MT, MAX_MB};
    else if (m[3:0] == 4'd0)    r = {m[7:4] - 4'd1, 4'd9};
    else                        r = {m[7:4], m[3:0] - 4'd1};
    return r;
  endfunction

  function automatic logic [7:0] sec_inc(input logic [7:0] s);
    logic [7:0] r;
    if (s == 8'h59)             r = 8'h00;
    else if (s[3:0] == 4'd9)    r = {s[7:4] + 4'd1, 4'd0};
    else                        r = {s[7:4], s[3:0] + 4'd1};
    return r;
  endfunction

  function automatic logic [7:0] sec_dec(input logic [7:0] s);
    logic [7:0] r;
    if (s == 8'h00)             r = 8'h59;
    else if (s[3:0] == 4'd0)    r = {s[7:4] - 4'd1, 4'd9};
    else                        r = {s[7:4], s[3:0] - 4'd1};
    return r;
  endfunction

  function automatic logic [15:0] bcd_up(input logic [15:0] c);
    return {(c[7:0] == 8'h59) ? min_inc(c[15:8]) : c[15:8], sec_inc(c[7:0])};
  endfunction

  function automatic logic [15:0] bcd_down(input logic [15:0] c);
    return {(c[7:0] == 8'h00) ? min_dec(c[15:8]) : c[15:8], sec_dec(c[7:0])};
  endfunction

  // Lap capture uses cnt_q, i.e. the value before any same-cycle tick.
  assign lap_pop  = lap_rd && !clear;
  assign lap_push = lap && !clear && (state_q == S_RUN || state_q == S_PAUSE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    tick_d  = tick_q;
    adjc_d  = adjc_q;
    ovf_d   = ovf_q;
    if (clear) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      tick_d  = '0;
      adjc_d  = '0;
      ovf_d   = 1'b0;
    end else begin
      if (lap_push && !fifo_push_rdy) begin
        ovf_d = 1'b1;
      end
      case (state_q)
        S_IDLE, S_PAUSE: begin
          if (adj) begin
            state_d = S_ADJUST;
            adjc_d  = '0;
          end else if (start_stop && !(mode && cnt_q == 16'h0000)) begin
            state_d = S_RUN;
            mode_d  = mode;
            if (state_q == S_IDLE) begin
              tick_d = '0;
            end
          end
        end
        S_RUN: begin
          if (adj) begin
            state_d = S_ADJUST;
            adjc_d  = '0;
          end else begin
            if (tick_q == TICK_LAST) begin
              tick_d = '0;
              if (!mode_q) begin
                cnt_d = bcd_up(cnt_q);
              end else begin
                cnt_d = bcd_down(cnt_q);
                if (cnt_d == 16'h0000) begin
                  state_d = S_ALARM;
                end
              end
            end else begin
              tick_d = tick_q + TW'(1);
            end
            // Reaching zero wins over a same-cycle pause request.
            if (start_stop && state_d == S_RUN) begin
              state_d = S_PAUSE;
            end
          end
        end
        S_ADJUST: begin
          if (!adj) begin
            state_d = S_PAUSE;
            adjc_d  = '0;
          end else if (adjc_q == ADJ_LAST) begin
            adjc_d = '0;
            if (sel) cnt_d[7:0]  = sec_inc(cnt_q[7:0]);
            else     cnt_d[15:8] = min_inc(cnt_q[15:8]);
          end else begin
            adjc_d = adjc_q + ADW'(1);
          end
        end
        S_ALARM: begin
          if (start_stop) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      tick_q  <= '0;
      adjc_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      tick_q  <= tick_d;
      adjc_q  <= adjc_d;
      ovf_q   <= ovf_d;
    end
  end

  fifo #(
    .W     (16),
    .DEPTH (LAP_DEPTH)
  ) u_lap_fifo (
    .core_clk (clk),
    .arst_n   (rst),
    .flush    (clear),
    .push_vld (lap_push),
    .push_dat (cnt_q),
    .push_rdy (fifo_push_rdy),
    .pop_rdy  (lap_pop),
    .head_vld (lap_valid),
    .head_dat (lap_data),
    .count    (lap_count)
  );

  assign {minutes_top, minutes_bot, seconds_top, seconds_bot} = cnt_q;
  assign running      = (state_q == S_RUN);
  assign alarm        = (state_q == S_ALARM);
  assign lap_overflow = ovf_q;
endmodule

// File: tb/tb_multimode_timer_core.sv
// Directed bench for multimode_timer_core: cycle-by-cycle vector table plus hand-written corner sequences.
module tb_multimode_timer_core;
  logic        clk = 1'b0;
  logic        rst;
  logic        start_stop, clear, mode, adj, sel, lap, lap_rd;
  logic [3:0]  minutes_top, minutes_bot, seconds_top, seconds_bot;
  logic        running, alarm, lap_valid, lap_overflow;
  logic [15:0] lap_data;
  logic [1:0]  lap_count;
  logic [15:0] digits;

  int checks   = 0;
  int failures = 0;

  multimode_timer_core #(
    .TICK_DIV  (4),
    .ADJ_DIV   (2),
    .MAX_MIN   (59),
    .LAP_DEPTH (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start_stop   (start_stop),
    .clear        (clear),
    .mode         (mode),
    .adj          (adj),
    .sel          (sel),
    .lap          (lap),
    .lap_rd       (lap_rd),
    .minutes_top  (minutes_top),
    .minutes_bot  (minutes_bot),
    .seconds_top  (seconds_top),
    .seconds_bot  (seconds_bot),
    .running      (running),
    .alarm        (alarm),
    .lap_data     (lap_data),
    .lap_valid    (lap_valid),
    .lap_count    (lap_count),
    .lap_overflow (lap_overflow)
  );

  always #5 clk = ~clk;

  assign digits = {minutes_top, minutes_bot, seconds_top, seconds_bot};

  // in = {start_stop, clear, mode, adj, sel, lap, lap_rd}
  typedef struct packed {
    logic [6:0]  in;
    logic [15:0] dig;
    logic        run;
    logic        alm;
    logic        vld;
    logic [1:0]  cnt;
    logic [15:0] dat;
    logic        ovf;
  } vec_t;

  vec_t vecs [20];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic adjust_steps(input logic s, input int n);
    adj = 1'b1;
    sel = s;
    cyc(2 * n + 1);
    adj = 1'b0;
    cyc(1);
  endtask

  task automatic pulse_ss();
    start_stop = 1'b1;
    cyc(1);
    start_stop = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
  endtask

  initial begin
    // Count up from start, three laps into a 2-deep FIFO, pops, push+pop corners, clear priority.
    vecs[0]  = '{7'b1000000, 16'h0000, 1'b1, 1'b0, 1'b0, 2'd0, 16'h0000, 1'b0};
    vecs[1]  = '{7'b0000000, 16'h0000, 1'b1, 1'b0, 1'b0, 2'd0, 16'h0000, 1'b0};
    vecs[2]  = '{7'b0000000, 16'h0000, 1'b1, 1'b0, 1'b0, 2'd0, 16'h0000, 1'b0};
    vecs[3]  = '{7'b0000000, 16'h0000, 1'b1, 1'b0, 1'b0, 2'd0, 16'h0000, 1'b0};
    vecs[4]  = '{7'b0000000, 16'h0001, 1'b1, 1'b0, 1'b0, 2'd0, 16'h0000, 1'b0};
    vecs[5]  = '{7'b0000000, 16'h0001, 1'b1, 1'b0, 1'b0, 2'd0, 16'h0000, 1'b0};
    vecs[6]  = '{7'b0000000, 16'h0001, 1'b1, 1'b0, 1'b0, 2'd0, 16'h0000, 1'b0};
    vecs[7]  = '{7'b0000000, 16'h0001, 1'b1, 1'b0, 1'b0, 2'd0, 16'h0000, 1'b0};
    vecs[8]  = '{7'b0000010, 16'h0002, 1'b1, 1'b0, 1'b1, 2'd1, 16'h0001, 1'b0};
    vecs[9]  = '{7'b0000000, 16'h0002, 1'b1, 1'b0, 1'b1, 2'd1, 16'h0001, 1'b0};
    vecs[10] = '{7'b0000000, 16'h0002, 1'b1, 1'b0, 1'b1, 2'd1, 16'h0001, 1'b0};
    vecs[11] = '{7'b0000000, 16'h0002, 1'b1, 1'b0, 1'b1, 2'd1, 16'h0001, 1'b0};
    vecs[12] = '{7'b0000010, 16'h0003, 1'b1, 1'b0, 1'b1, 2'd2, 16'h0001, 1'b0};
    vecs[13] = '{7'b0000010, 16'h0003, 1'b1, 1'b0, 1'b1, 2'd2, 16'h0001, 1'b1};
    vecs[14] = '{7'b0000011, 16'h0003, 1'b1, 1'b0, 1'b1, 2'd2, 16'h0002, 1'b1};
    vecs[15] = '{7'b0000001, 16'h0003, 1'b1, 1'b0, 1'b1, 2'd1, 16'h0003, 1'b1};
    vecs[16] = '{7'b0000001, 16'h0004, 1'b1, 1'b0, 1'b0, 2'd0, 16'h0003, 1'b1};
    vecs[17] = '{7'b0000011, 16'h0004, 1'b1, 1'b0, 1'b1, 2'd1, 16'h0004, 1'b1};
    vecs[18] = '{7'b1100000, 16'h0000, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0004, 1'b0};
    vecs[19] = '{7'b1010000, 16'h0000, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0004, 1'b0};

    {start_stop, clear, mode, adj, sel, lap, lap_rd} = 7'b0;
    rst = 1'b1;
    #1 rst = 1'b0;
    #7;
    chk("reset_digits", digits, 16'h0000);
    chk("reset_running", 16'(running), 16'd0);
    chk("reset_alarm", 16'(alarm), 16'd0);
    chk("reset_lap_valid", 16'(lap_valid), 16'd0);
    chk("reset_lap_count", 16'(lap_count), 16'd0);
    #4 rst = 1'b1;

    for (int i = 0; i < 20; i++) begin
      {start_stop, clear, mode, adj, sel, lap, lap_rd} = vecs[i].in;
      cyc(1);
      chk($sformatf("v%0d_digits", i), digits, vecs[i].dig);
      chk($sformatf("v%0d_running", i), 16'(running), 16'(vecs[i].run));
      chk($sformatf("v%0d_alarm", i), 16'(alarm), 16'(vecs[i].alm));
      chk($sformatf("v%0d_lap_valid", i), 16'(lap_valid), 16'(vecs[i].vld));
      chk($sformatf("v%0d_lap_count", i), 16'(lap_count), 16'(vecs[i].cnt));
      chk($sformatf("v%0d_lap_data", i), lap_data, vecs[i].dat);
      chk($sformatf("v%0d_lap_overflow", i), 16'(lap_overflow), 16'(vecs[i].ovf));
    end
    {start_stop, clear, mode, adj, sel, lap, lap_rd} = 7'b0;

    // Up-count wrap from 59:58 preloaded via adjust.
    adjust_steps(1'b0, 59);
    adjust_steps(1'b1, 58);
    chk("wrap_preload", digits, 16'h5958);
    chk("wrap_preload_paused", 16'(running), 16'd0);
    mode = 1'b0;
    pulse_ss();
    chk("wrap_running", 16'(running), 16'd1);
    cyc(3);
    chk("wrap_c3", digits, 16'h5958);
    cyc(1);
    chk("wrap_c4", digits, 16'h5959);
    cyc(4);
    chk("wrap_c8", digits, 16'h0000);
    chk("wrap_c8_running", 16'(running), 16'd1);
    cyc(4);
    chk("wrap_c12", digits, 16'h0001);
    pulse_clear();

    // Count down to alarm.
    adjust_steps(1'b1, 2);
    chk("down_preload", digits, 16'h0002);
    mode = 1'b1;
    pulse_ss();
    chk("down_running", 16'(running), 16'd1);
    cyc(4);
    chk("down_c4", digits, 16'h0001);
    chk("down_c4_alarm", 16'(alarm), 16'd0);
    cyc(3);
    chk("down_c7", digits, 16'h0001);
    chk("down_c7_running", 16'(running), 16'd1);
    cyc(1);
    chk("down_c8", digits, 16'h0000);
    chk("down_c8_alarm", 16'(alarm), 16'd1);
    chk("down_c8_running", 16'(running), 16'd0);
    adj = 1'b1;
    cyc(1);
    adj = 1'b0;
    chk("alarm_ignores_adj", 16'(alarm), 16'd1);
    cyc(2);
    chk("alarm_holds", 16'(alarm), 16'd1);
    chk("alarm_digits", digits, 16'h0000);
    pulse_ss();
    chk("alarm_exit", 16'(alarm), 16'd0);
    chk("alarm_exit_running", 16'(running), 16'd0);
    pulse_ss();
    chk("down_zero_start_ignored", 16'(running), 16'd0);
    cyc(4);
    chk("down_zero_stays", digits, 16'h0000);
    mode = 1'b0;

    // Pause preserves the partial second.
    pulse_clear();
    pulse_ss();
    cyc(1);
    pulse_ss();
    chk("pause_running", 16'(running), 16'd0);
    cyc(10);
    chk("pause_digits", digits, 16'h0000);
    chk("pause_still", 16'(running), 16'd0);
    pulse_ss();
    chk("resume_running", 16'(running), 16'd1);
    chk("resume_digits", digits, 16'h0000);
    cyc(1);
    chk("resume_c1", digits, 16'h0000);
    cyc(1);
    chk("resume_c2", digits, 16'h0001);
    pulse_clear();

    // Adjust wraps without carry.
    adjust_steps(1'b1, 58);
    adj = 1'b1;
    sel = 1'b1;
    cyc(1);
    chk("adj_e0", digits, 16'h0058);
    cyc(1);
    chk("adj_e1", digits, 16'h0058);
    cyc(1);
    chk("adj_e2", digits, 16'h0059);
    cyc(1);
    chk("adj_e3", digits, 16'h0059);
    cyc(1);
    chk("adj_e4_sec_wrap", digits, 16'h0000);
    adj = 1'b0;
    cyc(1);
    chk("adj_exit_digits", digits, 16'h0000);
    chk("adj_exit_running", 16'(running), 16'd0);
    adj = 1'b1;
    sel = 1'b0;
    cyc(1 + 2 * 59);
    chk("adj_min_59", digits, 16'h5900);
    cyc(2);
    chk("adj_min_wrap", digits, 16'h0000);
    adj = 1'b0;
    cyc(1);

    // Asynchronous reset mid-run.
    pulse_clear();
    pulse_ss();
    cyc(5);
    lap = 1'b1;
    cyc(1);
    lap = 1'b0;
    chk("pre_rst_running", 16'(running), 16'd1);
    chk("pre_rst_lap_valid", 16'(lap_valid), 16'd1);
    chk("pre_rst_lap_data", lap_data, 16'h0001);
    #1 rst = 1'b0;
    #1;
    chk("arst_digits", digits, 16'h0000);
    chk("arst_running", 16'(running), 16'd0);
    chk("arst_alarm", 16'(alarm), 16'd0);
    chk("arst_lap_valid", 16'(lap_valid), 16'd0);
    chk("arst_lap_data", lap_data, 16'h0000);
    chk("arst_lap_count", 16'(lap_count), 16'd0);
    chk("arst_lap_overflow", 16'(lap_overflow), 16'd0);
    #4 rst = 1'b1;
    cyc(1);
    chk("post_rst_idle", 16'(running), 16'd0);
    chk("post_rst_digits", digits, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
